// File: rtl/pkt_detector_core.sv
// Streaming energy packet detector: sliding-window mean power, trigger/hold FSM, mode mux.
// Define PKT_DET_COUNT_EN to add the 32-bit det_count burst counter port.
module pkt_detector_core #(
    parameter int IQ_W     = 16,
    parameter int WIN_LOG2 = 5,
    parameter int THR_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [2*IQ_W-1:0] i_data_tdata,
    input  logic              i_data_tvalid,
    output logic              i_data_tready,
    input  logic              i_data_tlast,
    output logic [2*IQ_W-1:0] o_data_tdata,
    output logic              o_data_tvalid,
    input  logic              o_data_tready,
    output logic              o_data_tlast,
    output logic              o_data_tuser,
    input  logic [THR_W-1:0]  pd_threshold,
    input  logic [THR_W-1:0]  noise_threshold,
    input  logic [CNT_W-1:0]  n_count,
    input  logic [CNT_W-1:0]  hold_time,
    input  logic [1:0]        sel_out
`ifdef PKT_DET_COUNT_EN
    ,
    output logic [31:0]       det_count
`endif
);
    localparam int DW    = 2 * IQ_W;
    localparam int SW    = DW + WIN_LOG2;
    localparam int DEPTH = 1 << WIN_LOG2;

    typedef enum logic [1:0] {SEARCH, ARM, DETECT} state_t;

    logic advance;
    assign advance       = !o_data_tvalid || o_data_tready;
    assign i_data_tready = advance;

    logic signed [IQ_W-1:0] in_i, in_q;
    logic signed [DW-1:0]   sq_i, sq_q;
    logic [DW-1:0]          in_p;
    assign in_i = i_data_tdata[DW-1:IQ_W];
    assign in_q = i_data_tdata[IQ_W-1:0];
    assign sq_i = in_i * in_i;
    assign sq_q = in_q * in_q;
    assign in_p = $unsigned(sq_i) + $unsigned(sq_q);

    logic          s1_valid, s1_last;
    logic [DW-1:0] s1_data, s1_p;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_p     <= '0;
        end else if (advance) begin
            s1_valid <= i_data_tvalid;
            s1_last  <= i_data_tlast;
            s1_data  <= i_data_tdata;
            s1_p     <= in_p;
        end
    end

    // Delay line contents are only read once filled, so it needs no reset.
    logic [DW-1:0]       dline [DEPTH];
    logic [WIN_LOG2-1:0] wptr;
    logic                filled;
    logic [DW-1:0]       p_old;
    assign p_old = filled ? dline[wptr] : '0;

    always_ff @(posedge ap_clk) begin
        if (advance && s1_valid)
            dline[wptr] <= s1_p;
    end

    logic          s2_valid, s2_last;
    logic [DW-1:0] s2_data;
    logic [SW-1:0] sum;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
            sum      <= '0;
            wptr     <= '0;
            filled   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_data  <= s1_data;
            if (s1_valid) begin
                sum  <= sum + SW'(s1_p) - SW'(p_old);
                wptr <= wptr + 1'b1;
                if (wptr == WIN_LOG2'(DEPTH - 1))
                    filled <= 1'b1;
            end
        end
    end

    logic [DW-1:0]       avg;
    logic [THR_W-1:0]    metric;
    logic [WIN_LOG2-1:0] unused_sum_lsbs;
    assign avg             = sum[WIN_LOG2 +: DW];
    assign metric          = avg[DW-1 -: THR_W];
    assign unused_sum_lsbs = sum[WIN_LOG2-1:0];

    state_t           state, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, hold, hold_nxt, n_min;
    logic [CNT_W:0]   cnt_inc;
    logic             above, flag, exit_det;

    assign n_min   = (n_count == '0) ? CNT_W'(1) : n_count;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign above   = metric > pd_threshold;

    always_comb begin
        st_nxt   = state;
        cnt_nxt  = cnt;
        hold_nxt = hold;
        flag     = 1'b0;
        exit_det = 1'b0;
        unique case (state)
            SEARCH: begin
                if (above) begin
                    if (n_min == CNT_W'(1)) begin
                        st_nxt   = DETECT;
                        cnt_nxt  = '0;
                        hold_nxt = hold_time;
                        flag     = 1'b1;
                    end else begin
                        st_nxt  = ARM;
                        cnt_nxt = CNT_W'(1);
                    end
                end
            end
            ARM: begin
                if (!above) begin
                    st_nxt  = SEARCH;
                    cnt_nxt = '0;
                end else if (cnt_inc >= {1'b0, n_min}) begin
                    st_nxt   = DETECT;
                    cnt_nxt  = '0;
                    hold_nxt = hold_time;
                    flag     = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            DETECT: begin
                flag = 1'b1;
                if (metric >= noise_threshold) begin
                    hold_nxt = hold_time;
                end else if (hold != '0) begin
                    hold_nxt = hold - 1'b1;
                end else begin
                    exit_det = 1'b1;
                    st_nxt   = SEARCH;
                end
            end
            default: st_nxt = SEARCH;
        endcase
    end

    logic          out_en, out_last;
    logic [DW-1:0] out_data;

    always_comb begin
        out_en   = 1'b1;
        out_data = s2_data;
        out_last = s2_last;
        case (sel_out)
            2'd1: out_data = avg;
            2'd2: begin
                out_en   = flag;
                out_last = exit_det;
            end
            2'd3: out_data = DW'(flag);
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            o_data_tvalid <= 1'b0;
            o_data_tdata  <= '0;
            o_data_tlast  <= 1'b0;
            o_data_tuser  <= 1'b0;
            state         <= SEARCH;
            cnt           <= '0;
            hold          <= '0;
        end else if (advance) begin
            o_data_tvalid <= s2_valid && out_en;
            if (s2_valid) begin
                o_data_tdata <= out_data;
                o_data_tlast <= out_last;
                o_data_tuser <= flag;
                state        <= st_nxt;
                cnt          <= cnt_nxt;
                hold         <= hold_nxt;
            end
        end
    end

`ifdef PKT_DET_COUNT_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)
            det_count <= '0;
        else if (advance && s2_valid && state != DETECT && st_nxt == DETECT)
            det_count <= det_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pkt_detector_core.sv
// Scoreboard bench for pkt_detector_core against a window-sum reference model.
// Also exercises det_count when PKT_DET_COUNT_EN is defined.
module tb_pkt_detector_core;
    localparam int IQ_W     = 16;
    localparam int WIN_LOG2 = 2;
    localparam int THR_W    = 16;
    localparam int CNT_W    = 16;
    localparam int WIN      = 1 << WIN_LOG2;

    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] i_data_tdata = '0;
    logic        i_data_tvalid = 1'b0;
    logic        i_data_tready;
    logic        i_data_tlast = 1'b0;
    logic [31:0] o_data_tdata;
    logic        o_data_tvalid;
    logic        o_data_tready = 1'b1;
    logic        o_data_tlast;
    logic        o_data_tuser;
    logic [15:0] pd_threshold = 16'h0100;
    logic [15:0] noise_threshold = 16'h0040;
    logic [15:0] n_count = 16'd3;
    logic [15:0] hold_time = 16'd2;
    logic [1:0]  sel_out = 2'd0;
`ifdef PKT_DET_COUNT_EN
    logic [31:0] det_count;
`endif

    pkt_detector_core #(
        .IQ_W(IQ_W), .WIN_LOG2(WIN_LOG2), .THR_W(THR_W), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .i_data_tdata(i_data_tdata), .i_data_tvalid(i_data_tvalid),
        .i_data_tready(i_data_tready), .i_data_tlast(i_data_tlast),
        .o_data_tdata(o_data_tdata), .o_data_tvalid(o_data_tvalid),
        .o_data_tready(o_data_tready), .o_data_tlast(o_data_tlast),
        .o_data_tuser(o_data_tuser),
        .pd_threshold(pd_threshold), .noise_threshold(noise_threshold),
        .n_count(n_count), .hold_time(hold_time), .sel_out(sel_out)
`ifdef PKT_DET_COUNT_EN
        , .det_count(det_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_beats = 0;
    int n_lasts = 0;
    bit rdy_rand = 1'b0;
    bit gap_rand = 1'b0;

    logic [33:0] exp_q[$];

    // Reference model: window sum taken directly over the last WIN powers.
    longint hist[$];
    int     m_state;
    longint m_cnt, m_hold;

    function automatic void model_reset();
        hist.delete();
        m_state = 0;
        m_cnt   = 0;
        m_hold  = 0;
    endfunction

    function automatic void model_push(logic [31:0] iq, logic lst);
        int     si, sq;
        longint p, s, a, m, nmin;
        bit     flag, ex;
        logic [31:0] d;
        si = int'($signed(iq[31:16]));
        sq = int'($signed(iq[15:0]));
        p = longint'(si) * si + longint'(sq) * sq;
        hist.push_back(p);
        if (hist.size() > WIN) void'(hist.pop_front());
        s = 0;
        foreach (hist[k]) s += hist[k];
        a = (s / WIN) % (64'd1 << 32);
        m = a / (64'd1 << (32 - THR_W));
        nmin = (n_count == 0) ? 1 : longint'(n_count);
        flag = 0;
        ex   = 0;
        if (m_state == 2) begin
            flag = 1;
            if (m >= noise_threshold) m_hold = hold_time;
            else if (m_hold != 0) m_hold--;
            else begin
                ex = 1;
                m_state = 0;
                m_cnt = 0;
            end
        end else if (m > pd_threshold) begin
            m_cnt = (m_state == 0) ? 1 : m_cnt + 1;
            m_state = 1;
            if (m_cnt >= nmin) begin
                m_state = 2;
                m_hold = hold_time;
                flag = 1;
            end
        end else begin
            m_state = 0;
            m_cnt = 0;
        end
        case (sel_out)
            2'd0: exp_q.push_back({iq, lst, flag});
            2'd1: exp_q.push_back({32'(a), lst, flag});
            2'd2: if (flag) exp_q.push_back({iq, ex, flag});
            default: exp_q.push_back({31'd0, flag, lst, flag});
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        o_data_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit          prev_stall = 1'b0;
    logic [33:0] held, cur, e;

    always @(negedge clk) begin
        cur = {o_data_tdata, o_data_tlast, o_data_tuser};
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!o_data_tvalid || cur !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b %h, required v=1 %h",
                             o_data_tvalid, cur, held);
                end
            end
            if (o_data_tvalid && o_data_tready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: got %h, required no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL beat: got %h, required %h", cur, e);
                    end
                end
                n_beats++;
                if (o_data_tlast) n_lasts++;
            end
            prev_stall = o_data_tvalid && !o_data_tready;
            held = cur;
        end
    end

    task automatic check(string name, longint got, longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat is taken.
    task automatic send(logic [31:0] iq, logic lst);
        bit acc = 0;
        int budget = 0;
        if (gap_rand && $urandom_range(0, 3) == 0) begin
            i_data_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        i_data_tdata  = iq;
        i_data_tlast  = lst;
        i_data_tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (i_data_tready) begin
                acc = 1;
                model_push(iq, lst);
            end
            @(posedge clk);
            #1;
            if (!acc && ++budget > 1000) begin
                fails++;
                $display("FAIL input_timeout: got no tready, required tready");
                i_data_tvalid = 1'b0;
                return;
            end
        end
        i_data_tvalid = 1'b0;
        i_data_tlast  = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (10) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_data_tvalid = 1'b0;
        ap_rst_n = 1'b0;
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        exp_q.delete();
        model_reset();
    endtask

    task automatic run_a(int n);
        for (int k = 0; k < n; k++) begin
            if (k < 8) send(32'h1000_1000, 1'b0);
            else send(32'h0, k == n - 1);
        end
    endtask

    task automatic run_rand(int n);
        bit loud = 0;
        int left = 0;
        logic [15:0] vi, vq;
        for (int k = 0; k < n; k++) begin
            if (left == 0) begin
                loud = !loud;
                left = $urandom_range(5, 40);
            end
            left--;
            vi = loud ? 16'($urandom_range(0, 16'h3000)) : 16'($urandom_range(0, 16'h100));
            vq = loud ? 16'($urandom_range(0, 16'h3000)) : 16'($urandom_range(0, 16'h100));
            if ($urandom_range(0, 1) == 1) vi = -vi;
            if ($urandom_range(0, 1) == 1) vq = -vq;
            send({vi, vq}, 1'($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge clk);
        check("rst_tvalid", o_data_tvalid, 0);
        check("rst_tdata", o_data_tdata, 0);
        check("rst_tlast", o_data_tlast, 0);
        check("rst_tuser", o_data_tuser, 0);
        check("rst_tready", i_data_tready, 1);
        @(posedge clk);
        #1;

        sel_out = 2'd0;
        run_a(20);
        drain();
`ifdef PKT_DET_COUNT_EN
        check("det_count", det_count, 1);
`endif
        do_reset();

        sel_out = 2'd2;
        n_beats = 0;
        n_lasts = 0;
        run_a(20);
        drain();
        check("gated_beats", n_beats, 10);
        check("gated_lasts", n_lasts, 1);
        do_reset();

        sel_out = 2'd1;
        run_a(20);
        drain();
        do_reset();

        sel_out = 2'd0;
        run_a(10);
        do_reset();
        @(negedge clk);
        check("midrst_tvalid", o_data_tvalid, 0);
        @(posedge clk);
        #1;
        run_a(20);
        drain();
        do_reset();

        n_count = 16'd0;
        hold_time = 16'd0;
        noise_threshold = 16'h0800;
        sel_out = 2'd2;
        n_beats = 0;
        send(32'h4000_0000, 1'b0);
        for (int k = 0; k < 6; k++) send(32'h0, 1'b0);
        drain();
        tests++;
        if (n_beats < 2) begin
            fails++;
            $display("FAIL ncount0_beats: got %0d, required >=2", n_beats);
        end
        do_reset();

        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            sel_out = (r == 0) ? 2'd0 : 2'(r);
            pd_threshold    = 16'($urandom_range(16'h80, 16'h300));
            noise_threshold = 16'($urandom_range(16'h20, 16'h100));
            n_count         = 16'($urandom_range(0, 5));
            hold_time       = 16'($urandom_range(0, 6));
            run_rand(r == 0 ? 1000 : 300);
            drain();
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_detector_core.md
# pkt_detector_core

Parametrised streaming energy packet detector for ORCA RFNoC blocks, sitting between the input and output pipeline FIFO flops inside a noc_block wrapper. It takes complex samples and computes a sliding-window mean power. A consecutive-count trigger and noise-floor hold decide the detect state. Depending on mode it emits the samples with a detect flag, the power metric, only the detected burst, or a flag word.

## Interface
- IQ_W, 16: I and Q sample width, signed.
- WIN_LOG2, 5: log2 of the power window length (window = 2^WIN_LOG2 samples, 1..10).
- THR_W, 16: width of the threshold and metric fields.
- CNT_W, 16: width of the count and hold registers.
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- i_data_tdata  in  2*IQ_W  {I, Q}, with I in the upper half.
- i_data_tvalid / i_data_tready / i_data_tlast  in/out/in  1  input AXI-Stream.
- o_data_tdata  out  2*IQ_W  output word; content depends on mode.
- o_data_tvalid / o_data_tready / o_data_tlast  out/in/out  1  output AXI-Stream.
- o_data_tuser  out  1  detect flag for the emitted sample.
- pd_threshold, noise_threshold  in  THR_W  trigger and hold thresholds, unsigned.
- n_count  in  CNT_W  consecutive samples above pd_threshold needed to trigger; 0 is treated as 1.
- hold_time  in  CNT_W  samples of hold after the metric drops below noise_threshold.
- sel_out  in  2  output mode.

## Operation
- Per accepted sample: p = I² + Q², unsigned, 2*IQ_W bits, no overflow (max 2^(2*IQ_W-1)).
- Sliding sum S (2*IQ_W+WIN_LOG2 bits): S ← S + p − p_old. p_old is the p from 2^WIN_LOG2 samples earlier. p_old is 0 for the first 2^WIN_LOG2 samples after reset.
- Mean A = S >> WIN_LOG2, truncated to 2*IQ_W bits. Metric M = the top THR_W bits of A.
- FSM, advanced once per sample at the decision stage:
  - SEARCH: if M > pd_threshold, set cnt=1. If cnt ≥ max(n_count,1), go to DETECT on this sample; otherwise go to ARM.
  - ARM: if M > pd_threshold, increment cnt, and go to DETECT when cnt reaches max(n_count,1). Otherwise clear cnt and go to SEARCH.
  - DETECT:
    - M ≥ noise_threshold: hold ← hold_time.
    - M < noise_threshold and hold ≠ 0: hold ← hold−1.
    - M < noise_threshold and hold = 0: this is the last detected sample; go to SEARCH.
  - Entering DETECT loads hold ← hold_time.
- The detect flag is 1 for every sample processed in DETECT, including the trigger sample and the exit sample.
- Output modes (sel_out is sampled per sample at the decision stage):
  - 0 (passthrough): tdata = input sample, tuser = detect flag, tlast = input tlast.
  - 1 (metric): tdata = A, tuser = detect flag, tlast = input tlast.
  - 2 (gated): only detected samples are emitted. tdata = sample. tlast = 1 on the exit sample. Input tlast is ignored.
  - 3 (flag): tdata = detect flag zero-extended, tuser = flag, tlast = input tlast.
- Thresholds, n_count and hold_time are sampled per sample. A change mid-burst takes effect on the next sample.

## Timing
- Pipeline, three stages: (1) input register and p; (2) S update and delay line; (3) FSM, mode mux and output register.
- Latency is 3 cycles from input handshake to o_data_tvalid when there is no backpressure. Throughput is 1 sample per cycle.
- Global advance = !o_data_tvalid || o_data_tready, and i_data_tready = advance. No beat is dropped or duplicated under any tready pattern.
- In mode 2, non-detected samples advance the pipeline but leave o_data_tvalid low.
- Output tdata, tlast and tuser stay stable while tvalid=1 and tready=0.
- Reset values: o_data_tvalid=0, o_data_tdata=0, o_data_tlast=0, o_data_tuser=0; i_data_tready=1 in the cycle after reset deasserts.
- Reset also clears S, the fill counter, the delay line read state, cnt and hold, and sets the FSM to SEARCH.
- Reset mid-burst discards all in-flight samples; no partial tlast is emitted.

## Configuration
- PKT_DET_COUNT_EN defined: adds an output port det_count (32 bits).
  - It increments on every entry to DETECT and wraps at 2^32.
  - Reset value is 0.
- PKT_DET_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use IQ_W=16, WIN_LOG2=2, THR_W=16.
- Constant I=Q=0x1000 for 8 samples, then zeros; pd_threshold=0x0100, n_count=3, noise_threshold=0x0040, hold_time=2, sel_out=0 → M = 0x80, 0x100, 0x180, 0x200…; tuser rises on input sample 5 and falls after sample 14.
- Same stimulus with sel_out=2 → exactly 10 beats (input samples 5–14), tlast only on the 10th beat.
- Same stimulus with sel_out=1 → tdata sequence 0x00800000, 0x01000000, 0x01800000, 0x02000000, …
- Random o_data_tready (50%) with 1000 random samples, sel_out=0 → the output sequence equals the input sequence bit-exactly, and no tdata change while stalled.
- n_count=0 with a single sample where M > pd_threshold → DETECT on that sample. With hold_time=0 and the next M < noise_threshold, detect lasts 2 samples.
- ap_rst_n low for 1 cycle mid-burst → tvalid=0 the next cycle; fresh stimulus reproduces the first scenario exactly. With PKT_DET_COUNT_EN defined, det_count = 1 after a single burst.
